// File: rtl/convolution_coprocessor_compare_pipe.sv
// convolution_coprocessor_compare_pipe
//
// Purpose:
//   Single-stage valid/ready compare pipe. Each accepted operand pair (A, B)
//   is compared according to mode_i, either as unsigned or as two's
//   complement, and the 1-bit result plus an equality flag are registered
//   for delivery one cycle later. A saturating counter tallies delivered
//   results that were true.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   valid_i   in   operand pair valid
//   ready_o   out  stage can accept an operand pair this cycle
//   A_i, B_i  in   operands, DATA_WIDTH bits
//   mode_i    in   compare select: 000 lt, 001 le, 010 gt, 011 ge,
//                  100 eq, 101 ne, 110/111 reserved (result 0)
//   signed_i  in   1 = two's complement compare, 0 = unsigned
//   clear_i   in   synchronous clear of count_o
//   valid_o   out  result_o/eq_o hold a valid result
//   ready_i   in   downstream accepts the result
//   result_o  out  comparison result for the selected mode
//   eq_o      out  A == B, independent of mode and signedness
//   count_o   out  saturating count of delivered true results

module convolution_coprocessor_compare_pipe #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic [2:0]            mode_i,
  input  logic                  signed_i,
  input  logic                  clear_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  result_o,
  output logic                  eq_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam logic       EMPTY   = 1'b0;
  localparam logic       FULL    = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  state_q;
  logic                  result_q;
  logic                  eq_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic                  in_xfer;
  logic                  out_xfer;
  logic [DATA_WIDTH-1:0] a_key;
  logic [DATA_WIDTH-1:0] b_key;
  logic                  lt;
  logic                  eq;
  logic                  cmp_result;

  assign valid_o  = (state_q == FULL);
  assign ready_o  = !valid_o || ready_i;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  assign result_o = result_q;
  assign eq_o     = eq_q;
  assign count_o  = count_q;

  // Flipping the sign bit maps two's complement order onto unsigned order,
  // so a single full-width unsigned compare serves both signedness modes,
  // including the most-negative value.
  assign a_key = {A_i[DATA_WIDTH-1] ^ signed_i, A_i[DATA_WIDTH-2:0]};
  assign b_key = {B_i[DATA_WIDTH-1] ^ signed_i, B_i[DATA_WIDTH-2:0]};
  assign lt    = (a_key < b_key);
  assign eq    = (A_i == B_i);

  always_comb begin
    cmp_result = 1'b0;
    case (mode_i)
      3'b000:  cmp_result = lt;
      3'b001:  cmp_result = lt || eq;
      3'b010:  cmp_result = !lt && !eq;
      3'b011:  cmp_result = !lt;
      3'b100:  cmp_result = eq;
      3'b101:  cmp_result = !eq;
      default: cmp_result = 1'b0;
    endcase
  end

  // Output register FSM. An accepted input always lands in FULL; FULL only
  // drains to EMPTY when the result leaves without a replacement arriving.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_q <= FULL;
        FULL:  if (out_xfer && !in_xfer) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (in_xfer) begin
        result_q <= cmp_result;
        eq_q     <= eq;
      end
    end
  end

  // Counts only results that actually leave the stage; clear wins over a
  // same-cycle increment and the counter sticks at its maximum.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (out_xfer && result_q && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_convolution_coprocessor_compare_pipe.sv
// tb_convolution_coprocessor_compare_pipe
//
// Purpose:
//   Directed self-checking bench. Two instances share all inputs: one with
//   the default 16-bit counter and one with a 2-bit counter so saturation
//   can be reached in a few transfers. Inputs change 1 ns after each rising
//   edge and outputs are observed at that same point.

module tb_convolution_coprocessor_compare_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic       ready_o_sat;
  logic [5:0] A_i;
  logic [5:0] B_i;
  logic [2:0] mode_i;
  logic       signed_i;
  logic       clear_i;
  logic       valid_o;
  logic       valid_o_sat;
  logic       ready_i;
  logic       result_o;
  logic       result_o_sat;
  logic       eq_o;
  logic       eq_o_sat;
  logic [15:0] count_o;
  logic [1:0]  count_o_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  convolution_coprocessor_compare_pipe #(.DATA_WIDTH(6), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(A_i), .B_i(B_i), .mode_i(mode_i), .signed_i(signed_i),
    .clear_i(clear_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .eq_o(eq_o), .count_o(count_o)
  );

  convolution_coprocessor_compare_pipe #(.DATA_WIDTH(6), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_sat),
    .A_i(A_i), .B_i(B_i), .mode_i(mode_i), .signed_i(signed_i),
    .clear_i(clear_i), .valid_o(valid_o_sat), .ready_i(ready_i),
    .result_o(result_o_sat), .eq_o(eq_o_sat), .count_o(count_o_sat)
  );

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b,
                       input logic [2:0] m, input logic s);
    valid_i  = v;
    A_i      = a;
    B_i      = b;
    mode_i   = m;
    signed_i = s;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    clear_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b exp 0", valid_o); end
    n_checks++; if (result_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_result got %b exp 0", result_o); end
    n_checks++; if (eq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_eq got %b exp 0", eq_o); end
    n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d exp 0", count_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_unsigned_lt();
    do_reset();
    drive(1'b1, 6'd5, 6'd9, 3'b000, 1'b0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b0);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ult_valid got %b exp 1", valid_o); end
    n_checks++; if (result_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ult_result got %b exp 1", result_o); end
    n_checks++; if (eq_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ult_eq got %b exp 0", eq_o); end
    n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("[TB] FAIL ult_count_pre got %0d exp 0", count_o); end
    tick();
    n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("[TB] FAIL ult_count got %0d exp 1", count_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ult_drain got %b exp 0", valid_o); end
  endtask

  // Columns: A, B, mode, signed, expected result, expected eq.
  task automatic test_signedness();
    logic [5:0] va [7];
    logic [5:0] vb [7];
    logic [2:0] vm [7];
    logic       vs [7];
    logic       vr [7];
    logic       ve [7];
    va = '{6'h3F, 6'h3F, 6'h20, 6'h20, 6'h03, 6'h03, 6'h20};
    vb = '{6'h01, 6'h01, 6'h1F, 6'h1F, 6'h28, 6'h28, 6'h20};
    vm = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001};
    vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, va[i], vb[i], vm[i], vs[i]);
      tick();
      n_checks++; if (result_o !== vr[i]) begin n_fail++; $display("[TB] FAIL signed_result[%0d] got %b exp %b", i, result_o, vr[i]); end
      n_checks++; if (eq_o !== ve[i]) begin n_fail++; $display("[TB] FAIL signed_eq[%0d] got %b exp %b", i, eq_o, ve[i]); end
    end
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
    n_checks++; if (count_o !== 16'd4) begin n_fail++; $display("[TB] FAIL signed_count got %0d exp 4", count_o); end
  endtask

  task automatic test_modes();
    logic [7:0] exp_res;
    exp_res = 8'b0001_1010;
    do_reset();
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 6'd12, 6'd12, 3'(m), m[0]);
      tick();
      n_checks++; if (result_o !== exp_res[m]) begin n_fail++; $display("[TB] FAIL mode_result[%0d] got %b exp %b", m, result_o, exp_res[m]); end
      n_checks++; if (eq_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mode_eq[%0d] got %b exp 1", m, eq_o); end
    end
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 6'd1, 6'd2, 3'b000, 1'b0);
    tick();
    drive(1'b1, 6'd7, 6'd3, 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready[%0d] got %b exp 0", c, ready_o); end
      n_checks++; if (valid_o !== 1'b1 || result_o !== 1'b1 || eq_o !== 1'b0)
        begin n_fail++; $display("[TB] FAIL bp_hold[%0d] got v%b r%b e%b exp v1 r1 e0", c, valid_o, result_o, eq_o); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready got %b exp 1", ready_o); end
    tick();
    n_checks++; if (valid_o !== 1'b1 || result_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_second got v%b r%b exp v1 r0", valid_o, result_o); end
    n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("[TB] FAIL bp_count1 got %0d exp 1", count_o); end
    drive(1'b1, 6'd4, 6'd4, 3'b100, 1'b0);
    tick();
    n_checks++; if (valid_o !== 1'b1 || result_o !== 1'b1 || eq_o !== 1'b1)
      begin n_fail++; $display("[TB] FAIL bp_third got v%b r%b e%b exp v1 r1 e1", valid_o, result_o, eq_o); end
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain got %b exp 0", valid_o); end
    n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("[TB] FAIL bp_count got %0d exp 2", count_o); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'd0, 6'd1, 3'b000, 1'b0);
      tick();
    end
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
    n_checks++; if (count_o_sat !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_count got %0d exp 3", count_o_sat); end
    n_checks++; if (count_o !== 16'd5) begin n_fail++; $display("[TB] FAIL wide_count got %0d exp 5", count_o); end
    drive(1'b1, 6'd0, 6'd1, 3'b000, 1'b0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n_checks++; if (count_o_sat !== 2'd0 || count_o !== 16'd0)
      begin n_fail++; $display("[TB] FAIL clear_prio got %0d/%0d exp 0/0", count_o_sat, count_o); end
    ready_i = 1'b0;
    drive(1'b1, 6'd0, 6'd1, 3'b000, 1'b0);
    tick();
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || result_o !== 1'b1)
      begin n_fail++; $display("[TB] FAIL clear_keeps_result got v%b r%b exp v1 r1", valid_o, result_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd2, 6'd9, 3'b000, 1'b0);
      tick();
    end
    n_checks++; if (valid_o !== 1'b1 || count_o !== 16'd2)
      begin n_fail++; $display("[TB] FAIL mid_setup got v%b c%0d exp v1 c2", valid_o, count_o); end
    rst_i   = 1'b1;
    clear_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0 || result_o !== 1'b0 || count_o !== 16'd0 || ready_o !== 1'b1)
      begin n_fail++; $display("[TB] FAIL mid_reset got v%b r%b c%0d rdy%b exp v0 r0 c0 rdy1", valid_o, result_o, count_o, ready_o); end
    rst_i = 1'b0;
    drive(1'b0, 6'd0, 6'd0, 3'd0, 1'b0);
    tick();
    n_checks++; if (valid_o !== 1'b0 || count_o !== 16'd0)
      begin n_fail++; $display("[TB] FAIL mid_discard got v%b c%0d exp v0 c0", valid_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_unsigned_lt();
    test_signedness();
    test_modes();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/convolution_coprocessor_compare_pipe.md
CONVOLUTION_COPROCESSOR_COMPARE_PIPE -- requirements
Module: convolution_coprocessor_compare_pipe

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 6, operand width in bits.
- CNT_WIDTH, 16, width of the true-result counter.
REQ-002 The block SHALL have these ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept an input this cycle.
- A_i  in  DATA_WIDTH  operand A.
- B_i  in  DATA_WIDTH  operand B.
- mode_i  in  3  comparison select, sampled with the operands.
- signed_i  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
- clear_i  in  1  synchronous clear of count_o.
- valid_o  out  1  result_o/eq_o hold a valid result.
- ready_i  in  1  downstream accepts the result.
- result_o  out  1  comparison result for the selected mode.
- eq_o  out  1  A == B for the same operands, independent of mode.
- count_o  out  CNT_WIDTH  number of delivered results with result_o = 1.

Function
REQ-003 An input transfer SHALL occur in any cycle where valid_i = 1 and ready_o = 1.
REQ-004 An output transfer SHALL occur in any cycle where valid_o = 1 and ready_i = 1.
REQ-005 ready_o SHALL equal (!valid_o || ready_i), combinationally, so the stage streams one result per cycle under continuous ready_i.
REQ-006 The output register SHALL implement a two-state FSM:
- EMPTY (valid_o = 0): input transfer -> FULL.
- FULL (valid_o = 1): output transfer with no input transfer -> EMPTY; output and input transfer in the same cycle -> stay FULL with the new result loaded; no output transfer -> hold.
REQ-007 Latency SHALL be 1 cycle: a result accepted at edge N SHALL appear on result_o/eq_o with valid_o = 1 after edge N.
REQ-008 While valid_o = 1 and ready_i = 0, result_o and eq_o SHALL hold stable.
REQ-009 mode_i encoding SHALL be: 000 A<B, 001 A<=B, 010 A>B, 011 A>=B, 100 A==B, 101 A!=B, 110/111 reserved -> result_o = 0.
REQ-010 With signed_i = 1, operands SHALL be compared as DATA_WIDTH-bit two's complement; with signed_i = 0, as unsigned. eq_o SHALL be unaffected by signed_i.
REQ-011 All comparisons SHALL be evaluated at full DATA_WIDTH without truncation, including for the most-negative value (MSB = 1, rest 0).
REQ-012 count_o SHALL increment by 1 on each output transfer whose result_o = 1.
REQ-013 count_o SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-014 If clear_i = 1, count_o SHALL become 0 at the next edge; clear_i SHALL take priority over a simultaneous increment.
REQ-015 clear_i SHALL NOT affect valid_o, result_o or eq_o.
REQ-016 valid_i asserted while ready_o = 0 SHALL be ignored; the block SHALL NOT buffer it.

Reset
REQ-017 On rst_i = 1 at a rising edge, the block SHALL set valid_o = 0, result_o = 0, eq_o = 0 and count_o = 0.
REQ-018 Reset SHALL override all concurrent transfers and clear_i. A result held in FULL SHALL be discarded and SHALL NOT be counted.
REQ-019 While rst_i = 1, ready_o SHALL read 1 (valid_o = 0); any input transfer in that cycle SHALL be discarded.

Verification
REQ-020 Unsigned LT: DATA_WIDTH = 6, mode = 000, signed_i = 0, A = 5, B = 9, ready_i = 1 -> next cycle valid_o = 1, result_o = 1, eq_o = 0, count_o = 1 after the transfer.
REQ-021 Signedness: A = 6'h3F, B = 6'h01, mode = 000 -> result_o = 1 with signed_i = 1 and 0 with signed_i = 0. Also A = 6'h20, B = 6'h1F, signed -> result_o = 1.
REQ-022 Backpressure: send 3 back-to-back inputs with ready_i = 0 for 4 cycles -> the first result is held stable, ready_o = 0 and the 2nd input is not accepted. After ready_i = 1, results stream at one per cycle in order.
REQ-023 All modes, including reserved: sweep mode 000-111 with A = B = 12 -> result_o = 0,1,0,1,1,0,0,0; eq_o = 1 throughout.
REQ-024 Saturation and clear: CNT_WIDTH = 2, deliver 5 true results -> count_o sticks at 3. Assert clear_i in the same cycle as a true output transfer -> count_o = 0.
REQ-025 Reset mid-operation: valid_o = 1, count_o = 2, assert rst_i -> next cycle valid_o = 0, result_o = 0, count_o = 0, ready_o = 1, and the held result is never delivered.
